// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse cipher.
// Blocks are 128 bits, byte 0 in the top bits, column-major (byte 4c+r = state[r][c]).
package aes_inv_cipher_iter_pkg;

    typedef logic [127:0]       state_t;
    typedef logic [7:0]         byte_t;
    typedef logic [0:15][7:0]   blk_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam int AES_NR_128 = 10;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gmul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic int byte_idx(input int r, input int c);
        return 4 * c + r;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t sq;
        byte_t r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8).
    function automatic byte_t inv_sbox(input byte_t b);
        byte_t y;
        y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_cipher_iter_round
    import aes_inv_cipher_iter_pkg::*;
(
    input  state_t state,
    input  state_t round_key,
    input  logic   last,
    output state_t next_state
);

    blk_t cur;
    blk_t key;
    blk_t sub;
    blk_t added;
    blk_t mixed;

    function automatic logic [31:0] inv_mix_col(input byte_t a0, input byte_t a1,
                                                input byte_t a2, input byte_t a3);
        return {gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3),
                gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3),
                gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3),
                gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3)};
    endfunction

    always_comb begin
        cur   = state;
        key   = round_key;
        sub   = '0;
        mixed = '0;
        // Row r takes its byte from column c-r: a right rotation by r.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sub[byte_idx(r, c)] = inv_sbox(cur[byte_idx(r, (c + 4 - r) % 4)]);
            end
        end
        added = sub ^ key;
        for (int c = 0; c < 4; c++) begin
            mixed[4*c +: 4] = inv_mix_col(added[4*c], added[4*c+1], added[4*c+2], added[4*c+3]);
        end
        next_state = last ? state_t'(added) : state_t'(mixed);
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched
// combinationally from an external store via key_idx.
module aes_inv_cipher_iter
    import aes_inv_cipher_iter_pkg::*;
#(
    parameter int NR     = AES_NR_128,
    parameter int KIDX_W = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      data_in,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [127:0]      round_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      data_out
);

    fsm_t              fsm;
    fsm_t              fsm_d;
    logic [KIDX_W-1:0] rnd;
    state_t            state_q;
    state_t            round_out;
    logic              live;
    logic              load;
    logic              step;
    logic              finish;
    logic              last;

    assign last      = (rnd == '0);
    assign out_valid = (fsm == DONE);

    aes_inv_cipher_iter_round u_round (
        .state      (state_q),
        .round_key  (round_key),
        .last       (last),
        .next_state (round_out)
    );

    // live keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm  <= IDLE;
            live <= 1'b0;
        end else begin
            fsm  <= fsm_d;
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd      <= KIDX_W'(NR);
            state_q  <= '0;
            data_out <= '0;
        end else begin
            if (load) begin
                state_q <= data_in ^ round_key;
                rnd     <= KIDX_W'(NR - 1);
            end
            if (step) begin
                state_q <= round_out;
                rnd     <= rnd - KIDX_W'(1);
            end
            if (finish) begin
                data_out <= round_out;
            end
        end
    end

    always_comb begin
        fsm_d    = fsm;
        in_ready = 1'b0;
        key_idx  = KIDX_W'(NR);
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = live;
                if (in_valid && live) begin
                    load  = 1'b1;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                key_idx = rnd;
                if (last) begin
                    finish = 1'b1;
                    fsm_d  = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter using the FIPS-197 C.1 and App B vectors.
module tb_aes_inv_cipher_iter;

    localparam int NR = 10;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] data_in = '0;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] data_out;

    logic [127:0] ks [2][11];
    logic         key_sel = 1'b0;
    logic [127:0] exp_q [$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           n_out = 0;
    int           cyc = 0;

    aes_inv_cipher_iter #(.NR(NR), .KIDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_idx   (key_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign round_key = (key_idx <= 4'd10) ? ks[key_sel][key_idx] : '0;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] s;
        sq = x;
        s  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gm(sq, sq);
            s  = gm(s, sq);
        end
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic sel, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0]), sbox_f(t[31:24])}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every completed output handshake is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %h, expected no output", data_out);
                end else begin
                    check("plaintext", data_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_ready(output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {127'b0, in_ready}, 128'd1);
        acc = cyc;
    endtask

    task automatic issue(input logic [127:0] ct, input logic [127:0] pt, input logic sel,
                         input bit expect_out, output int acc);
        key_sel  = sel;
        data_in  = ct;
        in_valid = 1'b1;
        wait_ready(acc);
        if (expect_out) exp_q.push_back(pt);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, acc2, n;
        bit ok_v, ok_d, ok_r;

        expand(1'b0, C1_KEY);
        expand(1'b1, B_KEY);
        check("rk10_c1", ks[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("rk10_b",  ks[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {127'b0, in_ready},  128'd0);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_data_out",  data_out, 128'd0);
        check("rst_key_idx",   key_idx, 128'd10);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

        // FIPS-197 C.1 with latency
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        issue(C1_CT, C1_PT, 1'b0, 1'b1, acc);
        wait_out_valid(n);
        check("latency", n, NR + 1);
        wait_drain(20);

        // FIPS-197 App B with key_idx sequence
        key_sel  = 1'b1;
        data_in  = B_CT;
        in_valid = 1'b1;
        wait_ready(acc);
        check("key_idx_idle", key_idx, 128'd10);
        exp_q.push_back(B_PT);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = NR - 1; i >= 0; i--) begin
            @(negedge clk);
            check("key_idx_run", key_idx, i);
        end
        wait_drain(20);

        // Backpressure, with an in_valid pulse while DONE
        out_ready = 1'b0;
        issue(C1_CT, C1_PT, 1'b0, 1'b1, acc);
        wait_out_valid(n);
        check("bp_out_valid", {127'b0, out_valid}, 128'd1);
        ok_v = 1'b1;
        ok_d = 1'b1;
        ok_r = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1;
                data_in  = B_CT;
            end
            if (i == 8) in_valid = 1'b0;
            @(negedge clk);
            if (!out_valid) ok_v = 1'b0;
            if (data_out !== C1_PT) ok_d = 1'b0;
            if (in_ready) ok_r = 1'b0;
        end
        check("bp_valid_held", {127'b0, ok_v}, 128'd1);
        check("bp_data_held",  {127'b0, ok_d}, 128'd1);
        check("bp_no_ready",   {127'b0, ok_r}, 128'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("release_in_ready",  {127'b0, in_ready},  128'd1);
        check("release_out_valid", {127'b0, out_valid}, 128'd0);
        check("release_data_kept", data_out, C1_PT);

        // Back-to-back with in_valid held high
        @(posedge clk);
        #1;
        key_sel  = 1'b0;
        data_in  = C1_CT;
        in_valid = 1'b1;
        wait_ready(acc1);
        exp_q.push_back(C1_PT);
        @(posedge clk);
        #1;
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_out_valid(n);
        data_in = B_CT;
        key_sel = 1'b1;
        exp_q.push_back(B_PT);
        wait_ready(acc2);
        check("b2b_interval", acc2 - acc1, NR + 2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain(40);

        // Reset mid-RUN aborts the block
        issue(C1_CT, C1_PT, 1'b0, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", {127'b0, out_valid}, 128'd0);
        check("abort_data_out",  data_out, 128'd0);
        check("abort_in_ready",  {127'b0, in_ready}, 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_release_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        issue(C1_CT, C1_PT, 1'b0, 1'b1, acc);
        wait_drain(40);

        repeat (3) @(negedge clk);
        check("output_count", n_out, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
